// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - Fetch-unit control/status bundle between decoder/ALU side and the PC sequencer
//
// master: drives start, branch_rel, taken, target, halt; observes prog_ctr, instr_valid, done, instr_count
// slave : the fetch sequencer (inst_fetch)
interface inst_fetch_if #(
  parameter int PC_W  = 10,
  parameter int OFF_W = 8
);
  logic             start;
  logic             branch_rel;
  logic             taken;
  logic [OFF_W-1:0] target;
  logic             halt;
  logic [PC_W-1:0]  prog_ctr;
  logic             instr_valid;
  logic             done;
  logic [15:0]      instr_count;

  modport master (
    output start, branch_rel, taken, target, halt,
    input  prog_ctr, instr_valid, done, instr_count
  );

  modport slave (
    input  start, branch_rel, taken, target, halt,
    output prog_ctr, instr_valid, done, instr_count
  );
endinterface

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - Program-counter sequencer with IDLE/RUN/DONE control and relative branches
//
// Ports:
//   clk_i   - clock, all state on rising edge
//   rst_ni  - asynchronous active-low reset
//   bus     - inst_fetch_if.slave (start, branch_rel, taken, target, halt in;
//             prog_ctr, instr_valid, done, instr_count out)
// Optional: define INST_FETCH_COUNT_EN to build the retired-instruction counter;
//           otherwise instr_count is tied to zero.
module inst_fetch #(
  parameter int PC_W  = 10,
  parameter int OFF_W = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  inst_fetch_if.slave   bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] offset_ext;

  // Sign-extend the branch offset; the add then wraps naturally modulo 2^PC_W.
  assign offset_ext = PC_W'($signed(bus.target));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RUN;
          pc_d    = '0;
        end
      end
      RUN: begin
        // Halt wins over a taken branch; PC stays on the halt instruction.
        if (bus.halt) begin
          state_d = DONE;
        end else if (bus.branch_rel && bus.taken) begin
          pc_d = pc_q + offset_ext;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign bus.prog_ctr    = pc_q;
  assign bus.instr_valid = (state_q == RUN);
  assign bus.done        = (state_q == DONE);

`ifdef INST_FETCH_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Cleared on entry to RUN, counts non-halt RUN cycles, saturates at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_q != RUN) && bus.start) begin
      cnt_d = '0;
    end else if ((state_q == RUN) && !bus.halt && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.instr_count = cnt_q;
`else
  assign bus.instr_count = '0;
`endif
endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - Self-checking bench for inst_fetch: directed literals plus randomized run vs behavioural model
module tb_inst_fetch;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inst_fetch_if #(.PC_W(10), .OFF_W(8)) bus_if ();

  inst_fetch #(.PC_W(10), .OFF_W(8)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_if)
  );

  int n_vec  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_vec++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sext8(input int t);
    return (t >= 128) ? t - 256 : t;
  endfunction

  function automatic int wrap10(input int v);
    return ((v % 1024) + 1024) % 1024;
  endfunction

  // Behavioural model: mode 0=idle, 1=running, 2=finished.
  int m_mode = 0;
  int m_pc   = 0;
  int m_cnt  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0;
      m_pc   = 0;
      m_cnt  = 0;
    end else if (m_mode != 1) begin
      if (bus_if.start) begin
        m_mode = 1;
        m_pc   = 0;
        m_cnt  = 0;
      end
    end else if (bus_if.halt) begin
      m_mode = 2;
    end else begin
      if (bus_if.branch_rel && bus_if.taken)
        m_pc = wrap10(m_pc + sext8(int'(bus_if.target)));
      else
        m_pc = wrap10(m_pc + 1);
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
    end
  end

  function automatic int exp_cnt();
`ifdef INST_FETCH_COUNT_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("prog_ctr",    32'(bus_if.prog_ctr),    m_pc);
      check("instr_valid", 32'(bus_if.instr_valid), int'(m_mode == 1));
      check("done",        32'(bus_if.done),        int'(m_mode == 2));
      check("instr_count", 32'(bus_if.instr_count), exp_cnt());
    end
  end

  task automatic cyc(input bit s, input bit br, input bit tk, input int tgt, input bit h);
    bus_if.start      = s;
    bus_if.branch_rel = br;
    bus_if.taken      = tk;
    bus_if.target     = 8'(tgt);
    bus_if.halt       = h;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    bus_if.start      = 1'b0;
    bus_if.branch_rel = 1'b0;
    bus_if.taken      = 1'b0;
    bus_if.target     = '0;
    bus_if.halt       = 1'b0;
    rst_n             = 1'b0;
    @(negedge clk);
    #1;
    check("rst_pc",    32'(bus_if.prog_ctr),    0);
    check("rst_valid", 32'(bus_if.instr_valid), 0);
    check("rst_done",  32'(bus_if.done),        0);
    check("rst_cnt",   32'(bus_if.instr_count), 0);
    chk_en = 1'b1;
    rst_n  = 1'b1;

    cyc(0, 0, 0, 0, 0);
    check("idle_pc", 32'(bus_if.prog_ctr), 0);

    // Start, five plain cycles, halt.
    cyc(1, 0, 0, 0, 0);
    check("run_pc0",    32'(bus_if.prog_ctr),    0);
    check("run_valid0", 32'(bus_if.instr_valid), 1);
    for (int i = 1; i <= 5; i++) begin
      cyc(0, 0, 0, 0, 0);
      check("seq_pc", 32'(bus_if.prog_ctr), i);
    end
    cyc(0, 0, 0, 0, 1);
    check("halt_pc",    32'(bus_if.prog_ctr), 5);
    check("halt_done",  32'(bus_if.done),     1);
`ifdef INST_FETCH_COUNT_EN
    check("halt_cnt",   32'(bus_if.instr_count), 5);
`else
    check("halt_cnt",   32'(bus_if.instr_count), 0);
`endif

    // Relative branches.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 1, 16, 0);
    check("br_to_10", 32'(bus_if.prog_ctr), 'h010);
    cyc(0, 1, 1, 'hFC, 0);
    check("br_neg4", 32'(bus_if.prog_ctr), 'h00C);
    cyc(0, 1, 1, 4, 0);
    cyc(0, 1, 0, 'hFC, 0);
    check("br_not_taken", 32'(bus_if.prog_ctr), 'h011);
    cyc(0, 1, 1, 'hEE, 0);
    check("br_to_3ff", 32'(bus_if.prog_ctr), 'h3FF);
    cyc(0, 0, 0, 0, 0);
    check("wrap_3ff", 32'(bus_if.prog_ctr), 'h000);
    cyc(0, 1, 1, 'h20, 0);
    cyc(0, 1, 1, 'h10, 1);
    check("halt_prio_pc",   32'(bus_if.prog_ctr), 'h020);
    check("halt_prio_done", 32'(bus_if.done),     1);

    // Negative wrap, self-loop, start ignored in RUN.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 1, 'hFC, 0);
    check("wrap_neg", 32'(bus_if.prog_ctr), 'h3FE);
    cyc(0, 1, 1, 0, 0);
    check("self_loop_pc",    32'(bus_if.prog_ctr),    'h3FE);
    check("self_loop_valid", 32'(bus_if.instr_valid), 1);
    cyc(1, 0, 0, 0, 0);
    check("start_in_run", 32'(bus_if.prog_ctr), 'h3FF);
    cyc(0, 1, 1, 8, 0);
    check("pc_7", 32'(bus_if.prog_ctr), 'h007);

    // Asynchronous reset mid-run.
    rst_n = 1'b0;
    #1;
    check("arst_pc",    32'(bus_if.prog_ctr),    0);
    check("arst_valid", 32'(bus_if.instr_valid), 0);
    check("arst_done",  32'(bus_if.done),        0);
    check("arst_cnt",   32'(bus_if.instr_count), 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0);
    check("post_rst_idle", 32'(bus_if.instr_valid), 0);

    // Restart from DONE clears the count.
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
`ifdef INST_FETCH_COUNT_EN
    check("run3_cnt", 32'(bus_if.instr_count), 3);
`else
    check("run3_cnt", 32'(bus_if.instr_count), 0);
`endif
    cyc(1, 0, 0, 0, 0);
    check("restart_pc",    32'(bus_if.prog_ctr),    0);
    check("restart_done",  32'(bus_if.done),        0);
    check("restart_valid", 32'(bus_if.instr_valid), 1);
    check("restart_cnt",   32'(bus_if.instr_count), 0);

    // Randomized traffic, including occasional resets.
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      cyc(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
          1'($urandom_range(0, 15) == 0));
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter PC_W, default 10, program-counter width in bits.
REQ-002 Parameter OFF_W, default 8, branch-offset width in bits, two's complement.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 Start  input  1  level request to begin or restart a program run.
REQ-006 BranchRel  input  1  from control decoder; current instruction is a relative branch.
REQ-007 Taken  input  1  from ALU; branch condition true this cycle.
REQ-008 Target  input  OFF_W  signed PC-relative offset from branch lookup table.
REQ-009 Halt  input  1  current instruction decodes as halt.
REQ-010 ProgCtr  output  PC_W  instruction ROM address of the current instruction.
REQ-011 InstrValid  output  1  high while ProgCtr addresses an instruction under execution.
REQ-012 Done  output  1  program finished; high in DONE state.
REQ-013 InstrCount  output  16  number of instructions retired in the current run.

Function
REQ-014 FSM states SHALL be IDLE, RUN, DONE; state, ProgCtr and InstrCount are registers.
REQ-015 IDLE: Start=1 -> RUN next edge, ProgCtr=0; Start=0 -> stay IDLE, ProgCtr held at 0.
REQ-016 RUN, Halt=1 -> DONE next edge, ProgCtr held (points at halt instruction).
REQ-017 RUN, Halt=0, BranchRel=1, Taken=1 -> ProgCtr <= ProgCtr + sign-extend(Target).
REQ-018 RUN, Halt=0, otherwise -> ProgCtr <= ProgCtr + 1.
REQ-019 PC arithmetic SHALL be modulo 2^PC_W: 0x3FF+1 -> 0x000; 0x002 + (-4) -> 0x3FE.
REQ-020 Halt SHALL take priority over a simultaneous taken branch.
REQ-021 BranchRel=1 with Taken=0 SHALL behave as sequential (+1).
REQ-022 Target=0 on a taken branch SHALL hold ProgCtr (legal self-loop), FSM stays RUN.
REQ-023 Start SHALL be ignored in RUN.
REQ-024 DONE: Done=1, ProgCtr held; Start=1 -> RUN next edge, ProgCtr=0, Done=0.
REQ-025 InstrValid SHALL equal (state==RUN), combinational from state register; Done=(state==DONE).
REQ-026 BranchRel, Taken, Target, Halt SHALL be ignored outside RUN.
REQ-027 Next-PC latency: one clock; ProgCtr changes only on rising Clk or Reset assertion.

Reset
REQ-028 Reset low SHALL immediately force state=IDLE, ProgCtr=0, InstrCount=0, Done=0, InstrValid=0.
REQ-029 Reset asserted mid-RUN SHALL abort the run; first edge after release evaluates IDLE rules.
REQ-030 Reset deassertion SHALL be assumed synchronized upstream; no internal synchronizer.

Configuration
REQ-031 Macro INST_FETCH_COUNT_EN SHALL gate the instruction counter.
REQ-032 Defined: InstrCount clears to 0 on entry to RUN, +1 each RUN cycle with Halt=0, saturates at 0xFFFF, holds in DONE/IDLE.
REQ-033 Undefined: no counter register; InstrCount port present, tied to 0.

Verification
REQ-034 Reset low, Start=0 -> ProgCtr=0, InstrValid=0, Done=0, InstrCount=0.
REQ-035 Start pulse, 5 plain cycles then Halt -> ProgCtr 0,1,2,3,4,5 held, Done=1 next edge, InstrCount=5 (macro on).
REQ-036 ProgCtr=0x010, BranchRel=1, Taken=1, Target=0xFC -> ProgCtr=0x00C; same with Taken=0 -> 0x011.
REQ-037 ProgCtr=0x3FF sequential -> 0x000; Halt and taken branch together at 0x020 -> DONE, ProgCtr=0x020.
REQ-038 Reset low during RUN at ProgCtr=0x007 -> outputs zero immediately; Start in DONE -> RUN at 0, Done=0, count cleared.
